// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low keypad matrix, debounces press and release, and
// reports the accepted key as {row_idx, col_idx}.
//
// Parameters
//   SCAN_DIV_W   : prescaler width, one scan tick every 2^SCAN_DIV_W clocks
//   DEBOUNCE_CNT : consecutive matching ticks for press/release (1..15)
//   REPEAT_TICKS : auto-repeat interval in ticks (1..255)
//
// Ports
//   clk       : in  system clock, rising edge
//   rst_n     : in  synchronous active-low reset
//   cols[3:0] : in  column sense, active-low (pulled up externally)
//   rows[3:0] : out row drive, active-low one-hot
//   key_code  : out code of last accepted key {row_idx, col_idx}
//   key_valid : out one-clock pulse when key_code is (re)issued
//   key_held  : out high while the accepted key stays pressed
//
// Build option
//   KEYPAD_REPEAT_EN : when defined, a held key re-pulses key_valid every
//                      REPEAT_TICKS ticks with key_code unchanged.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV_W   = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Elaboration-time guard on the legal parameter ranges.
    if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_CNT must be 1..15");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_TICKS must be 1..255");
    end

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t                r_state, w_state_nxt;
    logic [SCAN_DIV_W-1:0] r_presc;
    logic [3:0]            r_rows;
    logic [3:0]            r_pattern;
    logic [1:0]            r_row_idx, r_col_idx;
    logic [3:0]            r_db_cnt;
    logic [3:0]            r_key_code;
    logic                  r_key_valid, r_key_held;

    logic       w_tick, w_idle;
    logic [1:0] w_row_now, w_col_now;
    logic [3:0] w_db_inc, w_db_nxt, w_code_nxt;
    logic       w_rotate, w_capture, w_accept, w_release;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_MAX = 8'(REPEAT_TICKS);
    logic [7:0] r_rep_cnt, w_rep_inc, w_rep_nxt;
    logic       w_rep_fire;
    assign w_rep_inc = (r_rep_cnt == 8'hFF) ? r_rep_cnt : r_rep_cnt + 8'd1;
`endif

    assign w_tick   = &r_presc;
    assign w_idle   = &cols;
    assign w_db_inc = (r_db_cnt == 4'hF) ? r_db_cnt : r_db_cnt + 4'd1;

    // Row currently driven low, and lowest-index low column (lowest wins).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_row_now = 2'd0;
        case (r_rows)
            4'b1101: w_row_now = 2'd1;
            4'b1011: w_row_now = 2'd2;
            4'b0111: w_row_now = 2'd3;
            default: w_row_now = 2'd0;
        endcase
        w_col_now = 2'd0;
        if      (!cols[0]) w_col_now = 2'd0;
        else if (!cols[1]) w_col_now = 2'd1;
        else if (!cols[2]) w_col_now = 2'd2;
        else if (!cols[3]) w_col_now = 2'd3;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) r_state <= ST_SCAN;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; all transitions happen only on a scan tick.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_SCAN:
                    if (!w_idle) w_state_nxt = (DB_MAX == 4'd1) ? ST_HELD : ST_DEBOUNCE;
                ST_DEBOUNCE:
                    if (cols != r_pattern)      w_state_nxt = ST_SCAN;
                    else if (w_db_inc == DB_MAX) w_state_nxt = ST_HELD;
                ST_HELD:
                    if (w_idle) w_state_nxt = (DB_MAX == 4'd1) ? ST_SCAN : ST_RELEASE;
                ST_RELEASE:
                    if (!w_idle)                w_state_nxt = ST_HELD;
                    else if (w_db_inc == DB_MAX) w_state_nxt = ST_SCAN;
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    // Output / datapath control decode.
    always_comb begin
        rows       = r_rows;
        key_code   = r_key_code;
        key_valid  = r_key_valid;
        key_held   = r_key_held;
        w_rotate   = 1'b0;
        w_capture  = 1'b0;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        w_db_nxt   = r_db_cnt;
        w_code_nxt = {r_row_idx, r_col_idx};
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt  = r_rep_cnt;
        w_rep_fire = 1'b0;
`endif
        if (w_tick) begin
            case (r_state)
                ST_SCAN:
                    if (w_idle) begin
                        w_rotate = 1'b1;
                    end else begin
                        // The first sighting already counts as one matching tick.
                        w_capture  = 1'b1;
                        w_db_nxt   = 4'd1;
                        w_code_nxt = {w_row_now, w_col_now};
                        w_accept   = (DB_MAX == 4'd1);
                    end
                ST_DEBOUNCE:
                    if (cols == r_pattern) begin
                        w_db_nxt = w_db_inc;
                        w_accept = (w_db_inc == DB_MAX);
                    end else begin
                        w_rotate = 1'b1;
                        w_db_nxt = 4'd0;
                    end
                ST_HELD:
                    if (w_idle) begin
                        w_db_nxt = 4'd1;
                        if (DB_MAX == 4'd1) begin
                            w_release = 1'b1;
                            w_rotate  = 1'b1;
                            w_db_nxt  = 4'd0;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (w_rep_inc == REP_MAX) begin
                        w_rep_fire = 1'b1;
                        w_rep_nxt  = 8'd0;
                    end else begin
                        w_rep_nxt  = w_rep_inc;
                    end
`endif
                ST_RELEASE:
                    if (w_idle) begin
                        w_db_nxt = w_db_inc;
                        if (w_db_inc == DB_MAX) begin
                            w_release = 1'b1;
                            w_rotate  = 1'b1;
                            w_db_nxt  = 4'd0;
                        end
                    end else begin
                        // Key bounced back down: resume HELD silently.
                        w_db_nxt = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_nxt = 8'd0;
`endif
                    end
                default: ;
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (w_accept) w_rep_nxt = 8'd0;
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_rows      <= 4'b1110;
            r_pattern   <= 4'hF;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_db_cnt    <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 8'd0;
`endif
        end else begin
            r_presc     <= r_presc + SCAN_DIV_W'(1);
            r_key_valid <= 1'b0;
            r_db_cnt    <= w_db_nxt;
            if (w_rotate) r_rows <= {r_rows[2:0], r_rows[3]};
            if (w_capture) begin
                r_pattern <= cols;
                r_row_idx <= w_row_now;
                r_col_idx <= w_col_now;
            end
            if (w_accept) begin
                r_key_code  <= w_code_nxt;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
            end
            if (w_release) r_key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= w_rep_nxt;
            if (w_rep_fire) r_key_valid <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed and randomized stimulus for keypad_scanner with a tick-level
// behavioural model of the scanner (row number, mode, counts as integers).
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int W  = 2;
    localparam int DB = 3;
    localparam int RT = 4;
    localparam int PT = 1 << W;   // clocks per tick

    localparam int MD_SCAN = 0, MD_DEB = 1, MD_HELD = 2, MD_REL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cols = 4'hF;
    logic [3:0] rows, key_code;
    logic       key_valid, key_held;

    keypad_scanner #(
        .SCAN_DIV_W  (W),
        .DEBOUNCE_CNT(DB),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cols     (cols),
        .rows     (rows),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int n_valid = 0;
    int pulse_q[$];

    // Reference model state.
    int         m_presc, m_row, m_mode, m_cnt, m_rep, m_lrow, m_lcol;
    logic [3:0] m_pat, m_code;
    logic       m_valid, m_held, m_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [3:0] row_drive(input int r);
        return 4'hF ^ (4'b0001 << r);
    endfunction

    function automatic int lowest_low(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    task automatic m_accept();
        m_code  = 4'(m_lrow * 4 + m_lcol);
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_mode  = MD_HELD;
        m_rep   = 0;
    endtask

    task automatic m_release();
        m_held = 1'b0;
        m_row  = (m_row + 1) % 4;
        m_mode = MD_SCAN;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input logic [3:0] c, input logic rn);
        m_valid = 1'b0;
        m_tick  = 1'b0;
        if (!rn) begin
            m_presc = 0; m_row = 0; m_mode = MD_SCAN; m_cnt = 0; m_rep = 0;
            m_code = 4'd0; m_held = 1'b0;
            return;
        end
        m_tick  = (m_presc == PT - 1);
        m_presc = m_tick ? 0 : m_presc + 1;
        if (!m_tick) return;
        case (m_mode)
            MD_SCAN:
                if (c == 4'hF) m_row = (m_row + 1) % 4;
                else begin
                    m_pat = c; m_lrow = m_row; m_lcol = lowest_low(c); m_cnt = 1;
                    if (m_cnt >= DB) m_accept(); else m_mode = MD_DEB;
                end
            MD_DEB:
                if (c == m_pat) begin
                    m_cnt++;
                    if (m_cnt >= DB) m_accept();
                end else begin
                    m_mode = MD_SCAN; m_row = (m_row + 1) % 4; m_cnt = 0;
                end
            MD_HELD:
                if (c == 4'hF) begin
                    m_cnt = 1;
                    if (m_cnt >= DB) m_release(); else m_mode = MD_REL;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep == RT) begin m_valid = 1'b1; m_rep = 0; end
`endif
                end
            default:
                if (c == 4'hF) begin
                    m_cnt++;
                    if (m_cnt >= DB) m_release();
                end else begin
                    m_mode = MD_HELD; m_cnt = 0; m_rep = 0;
                end
        endcase
    endtask

    // One clock: model follows the same edge, outputs compared #1 later.
    task automatic step();
        @(posedge clk);
        model_edge(cols, rst_n);
        cycle++;
        #1;
        check("rows",      32'(rows),      32'(row_drive(m_row)));
        check("key_code",  32'(key_code),  32'(m_code));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_held",  32'(key_held),  32'(m_held));
        if (key_valid) begin
            n_valid++;
            pulse_q.push_back(cycle);
        end
    endtask

    task automatic run_ticks(input int n, input logic [3:0] c);
        int seen = 0;
        cols = c;
        for (int i = 0; i < (n + 1) * PT && seen < n; i++) begin
            step();
            if (m_tick) seen++;
        end
    endtask

    task automatic wait_row(input int r);
        cols = 4'hF;
        for (int i = 0; i < 8 * PT && m_row != r; i++) step();
        check("wait_row", 32'(rows), 32'(row_drive(r)));
    endtask

    logic [3:0] exp_seq [4];
    int         kr, npress, nrel;
    logic [3:0] kpat;

    initial begin
        exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011;
        exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1110;

        // Reset with idle columns.
        rst_n = 1'b0; cols = 4'hF;
        step(); step();
        check("reset rows",      32'(rows),      32'hE);
        check("reset key_valid", 32'(key_valid), 32'h0);
        rst_n = 1'b1;

        // Idle scan rotation, one row per tick.
        n_valid = 0;
        for (int t = 0; t < 4; t++) begin
            run_ticks(1, 4'hF);
            check("scan rotate", 32'(rows), 32'(exp_seq[t]));
        end
        check("idle no pulse", 32'(n_valid), 32'd0);

        // Press on row 2, column 2.
        wait_row(2);
        run_ticks(DB, 4'b1011);
        check("press code",  32'(key_code),  32'hA);
        check("press valid", 32'(key_valid), 32'h1);
        check("press held",  32'(key_held),  32'h1);
        step();
        check("valid one clock", 32'(key_valid), 32'h0);

        // Release interrupted by a re-press, then a full release.
        n_valid = 0;
        run_ticks(2, 4'hF);
        run_ticks(1, 4'b0111);
        check("repress held", 32'(key_held), 32'h1);
        check("repress no pulse", 32'(n_valid), 32'd0);
        run_ticks(DB, 4'hF);
        check("release held", 32'(key_held), 32'h0);
        check("release rows", 32'(rows),     32'h7);

        // Single-tick bounce on row 3.
        n_valid = 0;
        run_ticks(1, 4'b1110);
        run_ticks(1, 4'hF);
        check("bounce rows",     32'(rows),    32'hE);
        check("bounce no pulse", 32'(n_valid), 32'd0);

        // Two low columns on row 3: lowest column wins; then hold.
        wait_row(3);
        run_ticks(DB, 4'b0101);
        check("multi code", 32'(key_code), 32'hD);
        n_valid = 0;
        pulse_q.delete();
        run_ticks(3 * RT, 4'b0101);
`ifdef KEYPAD_REPEAT_EN
        check("repeat count", 32'(n_valid), 32'd3);
        if (pulse_q.size() == 3) begin
            check("repeat gap 1", 32'(pulse_q[1] - pulse_q[0]), 32'(RT * PT));
            check("repeat gap 2", 32'(pulse_q[2] - pulse_q[1]), 32'(RT * PT));
        end
`else
        check("no repeat", 32'(n_valid), 32'd0);
`endif
        check("hold code kept", 32'(key_code), 32'hD);
        run_ticks(DB, 4'hF);

        // Reset in the middle of DEBOUNCE.
        wait_row(1);
        run_ticks(1, 4'b1101);
        step();
        n_valid = 0;
        rst_n = 1'b0;
        step();
        check("abort rows",  32'(rows),      32'hE);
        check("abort held",  32'(key_held),  32'h0);
        check("abort valid", 32'(key_valid), 32'h0);
        rst_n = 1'b1;
        // The first tick after reset samples row 0.
        run_ticks(DB, 4'b1011);
        check("post-reset code",  32'(key_code), 32'h2);
        check("post-reset count", 32'(n_valid),  32'd1);
        run_ticks(DB, 4'hF);

        // Randomized key activity on an emulated matrix with bounce and resets.
        for (int it = 0; it < 40; it++) begin
            kr     = int'($urandom_range(3, 0));
            kpat   = 4'hF ^ (4'b0001 << $urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) kpat = kpat & (4'hF ^ (4'b0001 << $urandom_range(3, 0)));
            npress = int'($urandom_range(12, 1)) * PT;
            nrel   = int'($urandom_range(6, 1)) * PT;
            for (int k = 0; k < npress; k++) begin
                cols = (m_row == kr && $urandom_range(15, 0) != 0) ? kpat : 4'hF;
                step();
            end
            cols = 4'hF;
            for (int k = 0; k < nrel; k++) step();
            if ($urandom_range(9, 0) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
